// File: rtl/stack_alu_sequencer.sv
// Sequencer between an instruction source and a stack-based ALU. It checks stack occupancy,
// issues legal ops as a one-cycle strobe and returns the ALU result after a fixed latency.
module stack_alu_sequencer #(
  parameter int unsigned N       = 4,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [2:0]                   instr_op,
  input  logic [N-1:0]                 instr_data,
  output logic                         alu_en,
  output logic [2:0]                   alu_opcode,
  output logic [N-1:0]                 alu_input_data,
  input  logic [N-1:0]                 alu_output_data,
  input  logic                         alu_overflow,
  output logic                         result_valid,
  output logic [N-1:0]                 result_data,
  output logic                         result_ovf,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         err_underflow,
  output logic                         err_full,
  output logic                         ovf_seen,
  input  logic                         err_clr
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(ALU_LAT + 1);

  localparam logic [2:0] OpAdd  = 3'b100;
  localparam logic [2:0] OpMul  = 3'b101;
  localparam logic [2:0] OpPush = 3'b110;
  localparam logic [2:0] OpPop  = 3'b111;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [N-1:0]    data_q, data_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    res_data_q, res_data_d;
  logic            res_ovf_q, res_ovf_d;
  logic            err_uf_q, err_full_q, ovf_seen_q;
  logic            set_uf, set_full, set_ovf;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    data_d         = data_q;
    depth_d        = depth_q;
    cnt_d          = cnt_q;
    res_data_d     = res_data_q;
    res_ovf_d      = res_ovf_q;
    set_uf         = 1'b0;
    set_full       = 1'b0;
    set_ovf        = 1'b0;
    instr_ready    = 1'b0;
    alu_en         = 1'b0;
    alu_opcode     = 3'b000;
    alu_input_data = '0;
    result_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        // Ops with a clear MSB are nops and are simply consumed.
        if (instr_valid && instr_op[2]) begin
          op_d   = instr_op;
          data_d = instr_data;
          case (instr_op)
            OpAdd, OpMul: begin
              if (depth_q <= DW'(1)) set_uf = 1'b1;
              else                   state_d = StIssue;
            end
            OpPush: begin
              if (depth_q == DW'(DEPTH)) set_full = 1'b1;
              else                       state_d  = StIssue;
            end
            OpPop: begin
              if (depth_q == '0) set_uf = 1'b1;
              else               state_d = StIssue;
            end
            default: ;
          endcase
        end
      end
      StIssue: begin
        alu_en         = 1'b1;
        alu_opcode     = op_q;
        alu_input_data = data_q;
        depth_d        = (op_q == OpPush) ? depth_q + DW'(1) : depth_q - DW'(1);
        cnt_d          = CW'(ALU_LAT);
        state_d        = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_data_d = alu_output_data;
          res_ovf_d  = alu_overflow;
          state_d    = StDone;
        end
      end
      StDone: begin
        // A push result is captured but never reported.
        result_valid = (op_q != OpPush);
        set_ovf      = result_valid & res_ovf_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= 3'b000;
      data_q     <= '0;
      depth_q    <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      err_uf_q   <= 1'b0;
      err_full_q <= 1'b0;
      ovf_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      depth_q    <= depth_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
      // Set beats clear when both happen in the same cycle.
      err_uf_q   <= set_uf   | (err_uf_q   & ~err_clr);
      err_full_q <= set_full | (err_full_q & ~err_clr);
      ovf_seen_q <= set_ovf  | (ovf_seen_q & ~err_clr);
    end
  end

  assign result_data   = res_data_q;
  assign result_ovf    = res_ovf_q;
  assign depth         = depth_q;
  assign err_underflow = err_uf_q;
  assign err_full      = err_full_q;
  assign ovf_seen      = ovf_seen_q;

endmodule
